// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers, fixed-latency mult/div and mfhi/mflo/mthi/mtlo access.
// Define MDU_DIVZERO_KEEP_EN to leave HI/LO unchanged after a divide by zero.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mduOp,
    input  logic        mdu_start,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int DATA_W = 32;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Results are packed {HI, LO}.
    function automatic logic [2*DATA_W-1:0] mul_s(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] ax;
        logic signed [2*DATA_W-1:0] bx;
        ax = {{DATA_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[DATA_W-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [2*DATA_W-1:0] mul_u(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] ax;
        logic [2*DATA_W-1:0] bx;
        ax = {{DATA_W{1'b0}}, a};
        bx = {{DATA_W{1'b0}}, b};
        return ax * bx;
    endfunction

    // Most-negative / -1 overflows the quotient; it wraps back to the dividend with zero remainder.
    function automatic logic [2*DATA_W-1:0] div_s(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] q;
        logic signed [DATA_W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [2*DATA_W-1:0] div_u(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] pend_q, pend_d;
    logic [2*DATA_W-1:0] md_res;
    logic                is_md;
    logic                is_mult;
`ifdef MDU_DIVZERO_KEEP_EN
    logic                keep_q, keep_d;
    logic                div_zero;

    assign div_zero = !is_mult && (srcB == '0);
`endif

    assign is_md   = (mduOp >= OP_MULT) && (mduOp <= OP_DIVU);
    assign is_mult = (mduOp == OP_MULT) || (mduOp == OP_MULTU);

    always_comb begin
        case (mduOp)
            OP_MULT:  md_res = mul_s(srcA, srcB);
            OP_MULTU: md_res = mul_u(srcA, srcB);
            OP_DIV:   md_res = div_s(srcA, srcB);
            OP_DIVU:  md_res = div_u(srcA, srcB);
            default:  md_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
`ifdef MDU_DIVZERO_KEEP_EN
        keep_d  = keep_q;
`endif
        case (state_q)
            IDLE: begin
                if (mdu_start && is_md) begin
                    pend_d  = md_res;
                    cnt_d   = is_mult ? MULT_CNT : DIV_CNT;
                    state_d = BUSY;
`ifdef MDU_DIVZERO_KEEP_EN
                    keep_d  = div_zero;
`endif
                end else if (mduOp == OP_MTHI) begin
                    hi_d = srcA;
                end else if (mduOp == OP_MTLO) begin
                    lo_d = srcA;
                end
            end
            BUSY: begin
                // Any start or move-to while busy falls through here untouched.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef MDU_DIVZERO_KEEP_EN
                    if (!keep_q) begin
                        hi_d = pend_q[2*DATA_W-1:DATA_W];
                        lo_d = pend_q[DATA_W-1:0];
                    end
`else
                    hi_d = pend_q[2*DATA_W-1:DATA_W];
                    lo_d = pend_q[DATA_W-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
`ifdef MDU_DIVZERO_KEEP_EN
            keep_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
`ifdef MDU_DIVZERO_KEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

    assign busy    = (state_q == BUSY);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mdu_out = (mduOp == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table, hand-written corner sequences, randomized ops vs. a reference model.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mduOp;
    logic        mdu_start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;
    logic [31:0] mh;
    logic [31:0] ml;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t tbl[$];

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mduOp    (mduOp),
        .mdu_start(mdu_start),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .mdu_out  (mdu_out),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        vec_t v;
        v.nm = nm; v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo;
        return v;
    endfunction

    // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
            4'd2: begin p = ua * ub; mh = p[63:32]; ml = p[31:0]; end
            4'd3, 4'd4: begin
                if (b == 32'd0) begin
`ifndef MDU_DIVZERO_KEEP_EN
                    mh = a;
                    ml = 32'hFFFF_FFFF;
`endif
                end else if (op == 4'd3) begin
                    q = sa / sb; r = sa % sb;
                    mh = r[31:0]; ml = q[31:0];
                end else begin
                    p = ua / ub; mh = p[31:0];
                    p = ua % ub; mh = p[31:0];
                    p = ua / ub; ml = p[31:0];
                end
            end
            4'd7: mh = a;
            4'd8: ml = a;
            default: ;
        endcase
    endfunction

    task automatic md_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int want;
        want = (op <= 4'd2) ? MC : DC;
        @(negedge clk);
        mduOp = op; mdu_start = 1'b1; srcA = a; srcB = b;
        @(posedge clk); #1;
        mdu_start = 1'b0; mduOp = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " cycles"}, n, want);
        chk({nm, " hi"}, hi, ehi);
        chk({nm, " lo"}, lo, elo);
    endtask

    task automatic set_reg(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        mduOp = op; mdu_start = 1'b0; srcA = val;
        @(posedge clk); #1;
        mduOp = 4'd0;
    endtask

    initial begin
        int n;
        logic [3:0] op;
        logic [31:0] a, b;
        logic [3:0] ign[4];

        total = 0; bad = 0;
        rst_n = 1'b0; mduOp = 4'd5; mdu_start = 1'b0; srcA = '0; srcB = '0;
        mh = '0; ml = '0;

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset mdu_out", mdu_out, 32'd0);

        // first start accepted on the very first edge after release
        @(negedge clk);
        rst_n = 1'b1; mduOp = 4'd1; mdu_start = 1'b1; srcA = 32'hFFFF_FFFF; srcB = 32'd2;
        @(posedge clk); #1;
        mdu_start = 1'b0; mduOp = 4'd0; n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("first cycles", n, MC);
        chk("first hi", hi, 32'hFFFF_FFFF);
        chk("first lo", lo, 32'hFFFF_FFFE);

        tbl.push_back(mk("mult",      4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA));
        tbl.push_back(mk("multu",     4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA));
        tbl.push_back(mk("div",       4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD));
        tbl.push_back(mk("divu",      4'd4, 32'd7,         32'd2,         32'd1,         32'd3));
        tbl.push_back(mk("div ovf",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000));
        tbl.push_back(mk("mult min",  4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0));
        tbl.push_back(mk("div negb",  4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD));
        tbl.push_back(mk("divu big",  4'd4, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF));
        tbl.push_back(mk("multu max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1));
        foreach (tbl[i]) md_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);

        set_reg(4'd7, 32'h1234_5678);
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        mduOp = 4'd5; #1;
        chk("mfhi out", mdu_out, 32'h1234_5678);
        mduOp = 4'd6; #1;
        chk("mflo out", mdu_out, 32'd1);
        mduOp = 4'd0;

        // mult with a stray div start and mtlo during its busy window
        @(negedge clk);
        mduOp = 4'd1; mdu_start = 1'b1; srcA = 32'd6; srcB = 32'd7;
        @(posedge clk); #1;
        mdu_start = 1'b0; mduOp = 4'd0; n = 0;
        @(posedge clk); #1; n++;
        mduOp = 4'd3; mdu_start = 1'b1; srcA = 32'd100; srcB = 32'd3;
        @(posedge clk); #1; n++;
        mdu_start = 1'b0; mduOp = 4'd8; srcA = 32'hAAAA_AAAA;
        @(posedge clk); #1; n++;
        mduOp = 4'd0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("overlap cycles", n, MC);
        chk("overlap hi", hi, 32'd0);
        chk("overlap lo", lo, 32'd42);
        @(posedge clk); #1;
        chk("overlap no restart", {31'd0, busy}, 32'd0);

        ign[0] = 4'd0; ign[1] = 4'd5; ign[2] = 4'd9; ign[3] = 4'd15;
        foreach (ign[i]) begin
            @(negedge clk);
            mduOp = ign[i]; mdu_start = 1'b1; srcA = 32'd5; srcB = 32'd5;
            @(posedge clk); #1;
            mdu_start = 1'b0; mduOp = 4'd0;
            chk($sformatf("ignored op%0d busy", ign[i]), {31'd0, busy}, 32'd0);
            chk($sformatf("ignored op%0d lo", ign[i]), lo, 32'd42);
        end

        // reset in the middle of a divide
        set_reg(4'd7, 32'h55);
        @(negedge clk);
        mduOp = 4'd3; mdu_start = 1'b1; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        mdu_start = 1'b0; mduOp = 4'd0;
        repeat (3) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("postrst hi", hi, 32'd0);
        chk("postrst lo", lo, 32'd0);
        md_op("multu 2x3", 4'd2, 32'd2, 32'd3, 32'd0, 32'd6);

        set_reg(4'd7, 32'h11);
        set_reg(4'd8, 32'h11);
`ifdef MDU_DIVZERO_KEEP_EN
        md_op("divu by0", 4'd4, 32'd9, 32'd0, 32'h11, 32'h11);
`else
        md_op("divu by0", 4'd4, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
`endif

        a = $urandom; b = $urandom;
        set_reg(4'd7, a); model(4'd7, a, 32'd0);
        set_reg(4'd8, b); model(4'd8, b, 32'd0);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                op = 4'($urandom_range(1, 4));
                a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 5))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = $urandom_range(1, 20);
                    default: b = $urandom;
                endcase
                model(op, a, b);
                md_op($sformatf("rnd%0d op%0d", k, op), op, a, b, mh, ml);
            end else begin
                op = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8;
                a = $urandom;
                model(op, a, 32'd0);
                set_reg(op, a);
                mduOp = 4'd5; #1;
                chk($sformatf("rnd%0d mfhi", k), mdu_out, mh);
                mduOp = 4'd6; #1;
                chk($sformatf("rnd%0d mflo", k), mdu_out, ml);
                mduOp = 4'd0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for mult and multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for div and divu.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-004 Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mduOp  input  4  operation code (REQ-006)
- mdu_start  input  1  one-cycle pulse launching mult/multu/div/divu
- srcA  input  32  operand A (rs value / mthi, mtlo data)
- srcB  input  32  operand B (rt value)
- busy  output  1  operation in progress
- mdu_out  output  32  HI or LO read data
- hi  output  32  HI register
- lo  output  32  LO register

Function
REQ-005 SHALL hold 32-bit registers HI and LO, a busy flag, a 4-bit cycle counter and the pending result pair.
REQ-006 mduOp encoding SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9-15 SHALL act as none.
REQ-007 State machine SHALL have two states, IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-008 IDLE with mdu_start=1 and mduOp 1-4: SHALL compute the result from srcA/srcB sampled at that edge, load the counter with MULT_CYCLES (1/2) or DIV_CYCLES (3/4), and enter BUSY.
REQ-009 mult: {HI,LO} SHALL be the signed 64-bit product; multu SHALL be the unsigned 64-bit product.
REQ-010 div: LO SHALL be the signed quotient truncated toward zero, HI the remainder with the sign of the dividend; divu SHALL use the unsigned equivalents.
REQ-011 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-012 In BUSY the counter SHALL decrement once per cycle; on the edge where it reaches 0, HI/LO SHALL take the pending result and the state SHALL return to IDLE.
REQ-013 busy SHALL be high for exactly the configured number of cycles, starting the cycle after the start edge; the result SHALL be visible on hi/lo in the first cycle that busy=0.
REQ-014 mdu_start with mduOp 0 or 5-15 SHALL be ignored.
REQ-015 mdu_start while busy=1 SHALL be ignored: no restart, operand change or counter change.
REQ-016 mthi/mtlo in IDLE SHALL write srcA into HI/LO at the next edge, with no busy cycles.
REQ-017 mthi/mtlo while busy=1 SHALL be ignored, and the pending result SHALL overwrite both registers.
REQ-018 A start and an mthi/mtlo cannot share one cycle, since mduOp carries a single code.
REQ-019 mdu_out SHALL be combinational: HI when mduOp=5, otherwise LO; it SHALL reflect the registered value regardless of busy.
REQ-020 The controller stalls mf/mt/md instructions on busy or mdu_start; mdu SHALL not rely on that stall for correctness beyond REQ-015/017.

Reset
REQ-021 While rst_n=0, HI, LO, the counter and the pending result SHALL be 0, the state SHALL be IDLE and busy SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result, and HI/LO SHALL read 0.
REQ-023 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-024 Macro MDU_DIVZERO_KEEP_EN SHALL control divide-by-zero behaviour.
REQ-025 With MDU_DIVZERO_KEEP_EN defined, div/divu with srcB=0 SHALL still run the full busy period and then leave HI/LO unchanged.
REQ-026 Without MDU_DIVZERO_KEEP_EN, div/divu with srcB=0 SHALL write LO=0xFFFFFFFF and HI=srcA.

Verification
REQ-027 mult: srcA=0xFFFFFFFE, srcB=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-028 div: srcA=-7, srcB=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with srcA=7, srcB=2 -> LO=3, HI=1.
REQ-029 mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0; mduOp=5 -> mdu_out=0x12345678.
REQ-030 mult start, then on busy cycle 2 a div start and an mtlo 0xAAAAAAAA -> both ignored; product result appears after exactly 5 busy cycles.
REQ-031 div start, then rst_n low on busy cycle 4 -> busy=0 and HI=LO=0 immediately; a new multu 2x3 after release -> LO=6 after 5 busy cycles.
REQ-032 divu srcA=9, srcB=0 with HI=LO=0x11 beforehand -> macro defined: HI=LO=0x11 after 10 busy cycles; macro undefined: LO=0xFFFFFFFF, HI=9.
